utf8_stream_encoder: RTL and testbench
======================================

// Module: utf8_stream_encoder
// PURPOSE
// - Streaming transmitter: accepts one code point per valid/ready handshake and emits its UTF-8 bytes one per cycle on a byte valid/ready port.
// - Output side of a character pipeline; feeds byte sinks (UART, FIFO) from UTF-32 sources.
// - Classifies the code point on acceptance: invalid or out-of-range values flag err; optionally replaced with U+FFFD.
// PARAMETERS
// - CHK_RANGE  1  1: cp > 0x10FFFF invalid; 0: 0x110000..0x7FFFFFFF encoded in extended 4..6-byte form
// - ALLOW_SURR 0  1: surrogates D800..DFFF encoded as 3 bytes; 0: surrogates invalid
// PORTS
// - clk       in   1   clock, rising edge
// - rst_in    in   1   reset, asynchronous, active-low
// - cp_valid  in   1   code point offered
// - cp_ready  out  1   code point accepted when cp_valid & cp_ready
// - cp_data   in   32  code point (UTF-32 value)
// - b_valid   out  1   output byte valid
// - b_ready   in   1   sink takes byte when b_valid & b_ready
// - b_data    out  8   UTF-8 byte
// - b_first   out  1   b_data is lead byte of a sequence
// - b_last    out  1   b_data is final byte of a sequence
// - err       out  1   one-cycle pulse: accepted code point invalid
// - nonuni    out  1   one-cycle pulse with err: cause was cp > 0x10FFFF (incl. cp[31]=1)
// BEHAVIOUR
// - Reset (async, rst_in=0): state IDLE; b_valid=0, b_data=0, b_first=0, b_last=0, err=0, nonuni=0; cp_ready=1 once rst_in releases.
// - States: IDLE (no byte held), EMIT (byte held on b_*, remaining count rem in 0..5).
// - cp_ready = IDLE | (EMIT & rem==0 & b_ready); combinational, no dependence on cp_valid.
// - Accept cycle N -> b_valid=1 at N+1 with lead byte, b_first=1; one byte per b_ready cycle after.
// - Back-to-back: last-byte handshake and next accept in same cycle -> no bubble.
// - b_valid stays 1 and b_data/b_first/b_last stay stable until b_ready; no retraction.
// - Length: <0x80:1, <0x800:2, <0x10000:3, <0x200000:4, <0x4000000:5, <0x80000000:6.
// - Lead byte 0xxxxxxx / 110xxxxx / 1110xxxx / 11110xxx / 111110xx / 1111110x; trailers 10xxxxxx, MSB group first.
// - Invalid: cp[31]=1; or CHK_RANGE & cp>0x10FFFF; or !ALLOW_SURR & cp in D800..DFFF.
// - Invalid accept: err=1 (and nonuni if range cause) registered at N+1 for exactly one cycle; see CONFIGURATION for byte output.
// - Valid accept: err=0, nonuni=0.
// - Shift register holds payload; rem decrements on each b_ready handshake; rem==0 drives b_last.
// - Reset mid-sequence: remaining bytes discarded; no partial sequence after release.
// CONFIGURATION
// - Macro UTF8_STREAM_ENCODER_REPLACE_EN.
// - Defined: invalid code point encoded as U+FFFD (EF BF BD, 3 bytes), err pulse still raised.
// - Undefined: invalid code point dropped; no bytes emitted; state stays IDLE; cp_ready stays 1; err pulse only.
// STRUCTURE
// - Package utf8_pkg: CP_MAX=32'h0010FFFF, SURR_LO=16'hD800, SURR_HI=16'hDFFF, CP_REPL=16'hFFFD,
//   typedef enum logic {ENC_IDLE, ENC_EMIT} enc_state_t, typedef logic [2:0] utf8_len_t.
// - Sub-module utf8_enc_classify (combinational): cp_data, CHK_RANGE, ALLOW_SURR -> len, invalid, nonuni, lead byte.
// - Top: FSM, 30-bit payload shift register, rem counter, err/nonuni pulse regs.
// TESTING
// - cp 0x41 -> single byte 41, b_first=b_last=1, err=0.
// - cp 0x20AC -> E2 82 AC; b_first on E2, b_last on AC.
// - cp 0x1F600 -> F0 9F 98 80.
// - cp 0x7F then 0x80, b_ready=1 -> 7F, C2, 80 on consecutive cycles, no bubble.
// - cp 0xD800: macro on -> EF BF BD + err; macro off -> no bytes, err pulse 1 cycle.
// - CHK_RANGE=0, cp 0x7FFFFFFF -> FD BF BF BF BF BF; CHK_RANGE=1 -> err+nonuni.
// - b_ready low 3 cycles mid-sequence -> b_data held; rst_in low mid-sequence -> b_valid 0 immediately.

Source files
------------

// File: rtl/utf8_pkg.sv
// Shared constants and types for the UTF-8 stream encoder.
// Pure declarations: no latency, no flow control.
package utf8_pkg;

  localparam logic [31:0] CP_MAX  = 32'h0010FFFF;
  localparam logic [15:0] SURR_LO = 16'hD800;
  localparam logic [15:0] SURR_HI = 16'hDFFF;
  localparam logic [15:0] CP_REPL = 16'hFFFD;

  typedef enum logic {ENC_IDLE, ENC_EMIT} enc_state_t;
  typedef logic [2:0] utf8_len_t;

  // Trailer payload left-aligned so the first trailer group sits in [29:24].
  function automatic logic [29:0] trail_align(input logic [31:0] cp, input utf8_len_t len);
    logic [29:0] t;
    case (len)
      3'd2:    t = {cp[5:0], 24'b0};
      3'd3:    t = {cp[11:0], 18'b0};
      3'd4:    t = {cp[17:0], 12'b0};
      3'd5:    t = {cp[23:0], 6'b0};
      3'd6:    t = cp[29:0];
      default: t = 30'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/utf8_enc_classify.sv
// Combinational code point classifier: sequence length, validity and lead byte.
// Zero latency, no flow control.
module utf8_enc_classify
  import utf8_pkg::*;
#(
  parameter bit CHK_RANGE  = 1'b1,
  parameter bit ALLOW_SURR = 1'b0
) (
  input  logic [31:0] cp_data,
  output logic [2:0]  len,
  output logic        invalid,
  output logic        nonuni,
  output logic [7:0]  lead
);

  logic over;
  logic surr;

  always_comb begin
    over    = cp_data > CP_MAX;
    surr    = (cp_data >= {16'b0, SURR_LO}) && (cp_data <= {16'b0, SURR_HI});
    invalid = cp_data[31] || (CHK_RANGE && over) || (!ALLOW_SURR && surr);
    // cp[31]=1 is always above CP_MAX, so it is reported as a range cause too.
    nonuni  = invalid && over;

    if (cp_data < 32'h80) begin
      len  = 3'd1;
      lead = {1'b0, cp_data[6:0]};
    end else if (cp_data < 32'h800) begin
      len  = 3'd2;
      lead = {3'b110, cp_data[10:6]};
    end else if (cp_data < 32'h10000) begin
      len  = 3'd3;
      lead = {4'b1110, cp_data[15:12]};
    end else if (cp_data < 32'h200000) begin
      len  = 3'd4;
      lead = {5'b11110, cp_data[20:18]};
    end else if (cp_data < 32'h4000000) begin
      len  = 3'd5;
      lead = {6'b111110, cp_data[25:24]};
    end else begin
      len  = 3'd6;
      lead = {7'b1111110, cp_data[30]};
    end
  end

endmodule

// File: rtl/utf8_stream_encoder.sv
// UTF-32 to UTF-8 byte streamer; lead byte 1 cycle after accept, then one byte per b_ready.
// Bytes held until b_ready; cp_ready only when idle or on last-byte handshake. Option: UTF8_STREAM_ENCODER_REPLACE_EN.
module utf8_stream_encoder
  import utf8_pkg::*;
#(
  parameter bit CHK_RANGE  = 1'b1,
  parameter bit ALLOW_SURR = 1'b0
) (
  input  logic        clk,
  input  logic        rst_in,
  input  logic        cp_valid,
  output logic        cp_ready,
  input  logic [31:0] cp_data,
  output logic        b_valid,
  input  logic        b_ready,
  output logic [7:0]  b_data,
  output logic        b_first,
  output logic        b_last,
  output logic        err,
  output logic        nonuni
);

  enc_state_t  state, state_n;
  logic [2:0]  rem, rem_n;
  logic [29:0] sr, sr_n;
  logic [7:0]  data_n;
  logic        first_n;

  logic [2:0]  cls_len;
  logic        cls_inv;
  logic        cls_nonuni;
  logic [7:0]  cls_lead;

  utf8_len_t   enc_len;
  logic [7:0]  enc_lead;
  logic [31:0] enc_cp;
  logic        emit_en;
  logic        acc;
  logic        take;

  utf8_enc_classify #(
    .CHK_RANGE  (CHK_RANGE),
    .ALLOW_SURR (ALLOW_SURR)
  ) u_classify (
    .cp_data (cp_data),
    .len     (cls_len),
    .invalid (cls_inv),
    .nonuni  (cls_nonuni),
    .lead    (cls_lead)
  );

`ifdef UTF8_STREAM_ENCODER_REPLACE_EN
  assign emit_en  = 1'b1;
  assign enc_cp   = cls_inv ? {16'b0, CP_REPL} : cp_data;
  assign enc_len  = cls_inv ? 3'd3 : cls_len;
  assign enc_lead = cls_inv ? 8'hEF : cls_lead;
`else
  assign emit_en  = !cls_inv;
  assign enc_cp   = cp_data;
  assign enc_len  = cls_len;
  assign enc_lead = cls_lead;
`endif

  assign b_valid  = (state == ENC_EMIT);
  assign b_last   = b_valid && (rem == 3'd0);
  assign cp_ready = (state == ENC_IDLE) || (b_last && b_ready);
  assign acc      = cp_valid && cp_ready;
  assign take     = b_valid && b_ready;

  always_comb begin
    state_n = state;
    rem_n   = rem;
    sr_n    = sr;
    data_n  = b_data;
    first_n = b_first;

    if (take) begin
      first_n = 1'b0;
      if (rem != 3'd0) begin
        rem_n  = rem - 3'd1;
        data_n = {2'b10, sr[29:24]};
        sr_n   = {sr[23:0], 6'b0};
      end else begin
        state_n = ENC_IDLE;
      end
    end

    // An accept can only coincide with the final handshake, so it overrides it.
    if (acc && emit_en) begin
      state_n = ENC_EMIT;
      rem_n   = enc_len - 3'd1;
      data_n  = enc_lead;
      sr_n    = trail_align(enc_cp, enc_len);
      first_n = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state   <= ENC_IDLE;
      rem     <= 3'd0;
      sr      <= 30'b0;
      b_data  <= 8'h00;
      b_first <= 1'b0;
      err     <= 1'b0;
      nonuni  <= 1'b0;
    end else begin
      state   <= state_n;
      rem     <= rem_n;
      sr      <= sr_n;
      b_data  <= data_n;
      b_first <= first_n;
      err     <= acc && cls_inv;
      nonuni  <= acc && cls_nonuni;
    end
  end

endmodule

// File: tb/tb_utf8_stream_encoder.sv
// Directed bench for utf8_stream_encoder: default instance plus a CHK_RANGE=0 instance on shared inputs.
// Honours UTF8_STREAM_ENCODER_REPLACE_EN for the expected invalid-code-point behaviour.
module tb_utf8_stream_encoder;

  logic        clk;
  logic        rst_in;
  logic        cp_valid;
  logic [31:0] cp_data;
  logic        b_ready;

  logic        cp_ready, b_valid, b_first, b_last, err, nonuni;
  logic [7:0]  b_data;
  logic        cp_ready_x, b_valid_x, b_first_x, b_last_x, err_x, nonuni_x;
  logic [7:0]  b_data_x;

  int errors = 0;
  int checks = 0;

  logic [7:0] cap_data  [8];
  logic       cap_first [8];
  logic       cap_last  [8];
  int         cap_n;
  int         cap_err;
  int         cap_nonuni;

  utf8_stream_encoder dut (
    .clk(clk), .rst_in(rst_in), .cp_valid(cp_valid), .cp_ready(cp_ready),
    .cp_data(cp_data), .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .b_first(b_first), .b_last(b_last), .err(err), .nonuni(nonuni)
  );

  utf8_stream_encoder #(.CHK_RANGE(1'b0), .ALLOW_SURR(1'b0)) dut_x (
    .clk(clk), .rst_in(rst_in), .cp_valid(cp_valid), .cp_ready(cp_ready_x),
    .cp_data(cp_data), .b_valid(b_valid_x), .b_ready(b_ready), .b_data(b_data_x),
    .b_first(b_first_x), .b_last(b_last_x), .err(err_x), .nonuni(nonuni_x)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offer one code point with the sink always ready, then record 8 cycles of output.
  task automatic run_cp(input bit sel, input logic [31:0] cp);
    cap_n = 0; cap_err = 0; cap_nonuni = 0;
    b_ready = 1'b1; cp_valid = 1'b1; cp_data = cp;
    @(posedge clk); #1;
    cp_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (sel ? b_valid_x : b_valid) begin
        if (cap_n < 8) begin
          cap_data[cap_n]  = sel ? b_data_x : b_data;
          cap_first[cap_n] = sel ? b_first_x : b_first;
          cap_last[cap_n]  = sel ? b_last_x : b_last;
        end
        cap_n++;
      end
      if (sel ? err_x : err) cap_err++;
      if (sel ? nonuni_x : nonuni) cap_nonuni++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b0; cp_valid = 1'b0; cp_data = 32'h0; b_ready = 1'b0;
    #2;
    checks++; if (b_valid !== 1'b0) begin errors++; $display("FAIL reset_b_valid got=%b exp=0", b_valid); end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({b_data, b_first, b_last, err, nonuni} !== 12'h000) begin
      errors++; $display("FAIL reset_outputs got data=%h first=%b last=%b err=%b nonuni=%b exp all 0",
                         b_data, b_first, b_last, err, nonuni);
    end
    rst_in = 1'b1;
    @(posedge clk); #1;
    checks++; if (cp_ready !== 1'b1) begin errors++; $display("FAIL reset_cp_ready got=%b exp=1", cp_ready); end
    checks++; if (b_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_b_valid got=%b exp=0", b_valid); end
  endtask

  task automatic test_encode();
    logic [31:0] cps  [5];
    int          lens [5];
    logic [7:0]  exp  [5][4];
    cps  = '{32'h41, 32'h20AC, 32'h1F600, 32'hE000, 32'h10FFFF};
    lens = '{1, 3, 4, 3, 4};
    exp  = '{'{8'h41, 8'h00, 8'h00, 8'h00},
             '{8'hE2, 8'h82, 8'hAC, 8'h00},
             '{8'hF0, 8'h9F, 8'h98, 8'h80},
             '{8'hEE, 8'h80, 8'h80, 8'h00},
             '{8'hF4, 8'h8F, 8'hBF, 8'hBF}};
    for (int t = 0; t < 5; t++) begin
      run_cp(1'b0, cps[t]);
      checks++;
      if (cap_n !== lens[t]) begin
        errors++; $display("FAIL enc_len cp=%h got=%0d exp=%0d", cps[t], cap_n, lens[t]);
      end else begin
        for (int i = 0; i < lens[t]; i++) begin
          checks++;
          if (cap_data[i] !== exp[t][i] || cap_first[i] !== (i == 0) || cap_last[i] !== (i == lens[t] - 1)) begin
            errors++; $display("FAIL enc_byte cp=%h idx=%0d got=%h/f%b/l%b exp=%h/f%b/l%b", cps[t], i,
                               cap_data[i], cap_first[i], cap_last[i], exp[t][i], i == 0, i == lens[t] - 1);
          end
        end
      end
      checks++;
      if (cap_err !== 0 || cap_nonuni !== 0) begin
        errors++; $display("FAIL enc_err cp=%h got err=%0d nonuni=%0d exp 0", cps[t], cap_err, cap_nonuni);
      end
    end
  endtask

  task automatic test_back_to_back();
    b_ready = 1'b1; cp_valid = 1'b1; cp_data = 32'h7F;
    @(posedge clk); #1;
    checks++;
    if (b_valid !== 1'b1 || b_data !== 8'h7F || b_last !== 1'b1 || cp_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_first got v=%b d=%h l=%b rdy=%b exp v=1 d=7f l=1 rdy=1", b_valid, b_data, b_last, cp_ready);
    end
    cp_data = 32'h80;
    @(posedge clk); #1;
    cp_valid = 1'b0;
    checks++;
    if (b_valid !== 1'b1 || b_data !== 8'hC2 || b_first !== 1'b1) begin
      errors++; $display("FAIL b2b_second got v=%b d=%h f=%b exp v=1 d=c2 f=1", b_valid, b_data, b_first);
    end
    @(posedge clk); #1;
    checks++;
    if (b_valid !== 1'b1 || b_data !== 8'h80 || b_last !== 1'b1 || b_first !== 1'b0) begin
      errors++; $display("FAIL b2b_third got v=%b d=%h f=%b l=%b exp v=1 d=80 f=0 l=1", b_valid, b_data, b_first, b_last);
    end
    @(posedge clk); #1;
    checks++; if (b_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b exp=0", b_valid); end
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_invalid();
    run_cp(1'b0, 32'hD800);
    checks++;
    if (cap_err !== 1 || cap_nonuni !== 0) begin
      errors++; $display("FAIL surr_err got err=%0d nonuni=%0d exp err=1 nonuni=0", cap_err, cap_nonuni);
    end
`ifdef UTF8_STREAM_ENCODER_REPLACE_EN
    checks++;
    if (cap_n !== 3 || cap_data[0] !== 8'hEF || cap_data[1] !== 8'hBF || cap_data[2] !== 8'hBD || cap_last[2] !== 1'b1) begin
      errors++; $display("FAIL surr_repl got n=%0d %h %h %h exp n=3 ef bf bd", cap_n, cap_data[0], cap_data[1], cap_data[2]);
    end
`else
    checks++; if (cap_n !== 0) begin errors++; $display("FAIL surr_drop got bytes=%0d exp=0", cap_n); end
`endif
    checks++; if (cp_ready !== 1'b1) begin errors++; $display("FAIL surr_cp_ready got=%b exp=1", cp_ready); end
  endtask

  task automatic test_range();
    run_cp(1'b1, 32'h7FFFFFFF);
    checks++;
    if (cap_n !== 6 || cap_err !== 0) begin
      errors++; $display("FAIL ext_len got n=%0d err=%0d exp n=6 err=0", cap_n, cap_err);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (cap_data[i] !== ((i == 0) ? 8'hFD : 8'hBF)) begin
          errors++; $display("FAIL ext_byte idx=%0d got=%h exp=%h", i, cap_data[i], (i == 0) ? 8'hFD : 8'hBF);
        end
      end
    end
    run_cp(1'b0, 32'h7FFFFFFF);
    checks++;
    if (cap_err !== 1 || cap_nonuni !== 1) begin
      errors++; $display("FAIL range_err got err=%0d nonuni=%0d exp 1 1", cap_err, cap_nonuni);
    end
    run_cp(1'b0, 32'h110000);
    checks++;
    if (cap_err !== 1 || cap_nonuni !== 1) begin
      errors++; $display("FAIL range_edge got err=%0d nonuni=%0d exp 1 1", cap_err, cap_nonuni);
    end
`ifndef UTF8_STREAM_ENCODER_REPLACE_EN
    checks++; if (cap_n !== 0) begin errors++; $display("FAIL range_drop got bytes=%0d exp=0", cap_n); end
`else
    checks++; if (cap_n !== 3) begin errors++; $display("FAIL range_repl got bytes=%0d exp=3", cap_n); end
`endif
    run_cp(1'b1, 32'h80000000);
    checks++;
    if (cap_err !== 1 || cap_nonuni !== 1) begin
      errors++; $display("FAIL msb_err got err=%0d nonuni=%0d exp 1 1", cap_err, cap_nonuni);
    end
  endtask

  task automatic test_backpressure_reset();
    int bad;
    b_ready = 1'b0; cp_valid = 1'b1; cp_data = 32'h20AC;
    @(posedge clk); #1;
    cp_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (b_valid !== 1'b1 || b_data !== 8'hE2 || b_first !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold_lead got bad_cycles=%0d exp=0", bad); end
    b_ready = 1'b1;
    @(posedge clk); #1;
    b_ready = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (b_valid !== 1'b1 || b_data !== 8'h82 || b_first !== 1'b0 || b_last !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold_mid got bad_cycles=%0d exp=0 data=%h", bad, b_data); end
    rst_in = 1'b0;
    #1;
    checks++; if (b_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_b_valid got=%b exp=0", b_valid); end
    @(posedge clk); #1;
    rst_in = 1'b1;
    b_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (b_valid !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rst_no_partial got bad_cycles=%0d exp=0", bad); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_encode();
    test_back_to_back();
    test_invalid();
    test_range();
    test_backpressure_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
